// File: rtl/demux_dispatch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_pkg
//  Purpose  : Shared types and constants for the 1:4 demux dispatch
//             controller and its round-robin picker.
//  Contents : NUM_CH, SEL_W, mode encodings, holding-stage state type.
//  Revision : 1.0 - initial release
// ============================================================================
package demux_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   // cfg_mode encodings
   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   // One-entry holding stage: empty or holding a word
   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } state_e;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_dispatch_ctrl_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : demux_rr_pick
//  Purpose  : Combinational first-set search of a 4-bit mask, starting at a
//             2-bit pointer and wrapping modulo 4. Reusable by any 4-way
//             round-robin arbiter.
//  Ports    : mask_i  [3:0] candidate mask
//             start_i [1:0] first index examined
//             idx_o   [1:0] first set index at or after start_i (mod 4)
//             found_o       mask_i has at least one bit set
//  Revision : 1.0 - initial release
// ============================================================================
module demux_rr_pick (
   input  logic [3:0] mask_i,
   input  logic [1:0] start_i,
   output logic [1:0] idx_o,
   output logic       found_o
);

   // Walk offsets from farthest to nearest so the nearest set bit is the
   // last (winning) assignment. 2-bit addition gives the wrap 3 -> 0.
   always_comb begin
      idx_o   = start_i;
      found_o = 1'b0;
      for (int k = 3; k >= 0; k--) begin
         if (mask_i[start_i + 2'(k)]) begin
            idx_o   = start_i + 2'(k);
            found_o = 1'b1;
         end
      end
   end

endmodule : demux_rr_pick
`default_nettype wire

// File: rtl/demux_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : demux_dispatch_ctrl
//  Purpose  : Sequencing controller for a 1:4 demux. Registers each input
//             word in a one-entry holding stage and steers it to one output
//             channel, chosen round-robin over ch_en or fixed by cfg_sel.
//  Ports    : clk, rst (async, active high)
//             in_valid / in_ready / in_data   : producer stream
//             cfg_mode (0 RR, 1 fixed), cfg_sel, ch_en : channel policy
//             out_valid (one-hot) / out_ready : per-channel handshake
//             out_data, out_sel, busy          : held word, its select, full
//  Revision : 1.0 - initial release
// ============================================================================
module demux_dispatch_ctrl #(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_W-1:0]           in_data,
   input  logic                        cfg_mode,
   input  logic [demux_pkg::SEL_W-1:0] cfg_sel,
   input  logic [NUM_CH-1:0]           ch_en,
   output logic [NUM_CH-1:0]           out_valid,
   input  logic [NUM_CH-1:0]           out_ready,
   output logic [DATA_W-1:0]           out_data,
   output logic [demux_pkg::SEL_W-1:0] out_sel,
   output logic                        busy
);

   import demux_pkg::*;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   data_q,  data_d;
   logic [SEL_W-1:0]    sel_q,   sel_d;
   logic [SEL_W-1:0]    ptr_q,   ptr_d;

   logic                w_full;
   logic                w_fire;
   logic                w_acc;
   logic                w_pick_ok;
   logic [SEL_W-1:0]    w_sel_inc;
   logic [SEL_W-1:0]    w_ptr_eff;
   logic [SEL_W-1:0]    w_rr_idx;
   logic                w_rr_found;
   logic [SEL_W-1:0]    w_pick;
   logic [NUM_CH-1:0]   w_onehot;

   assign w_full    = (state_q == ST_HOLD);
   assign w_fire    = w_full & out_ready[sel_q];
   assign w_sel_inc = sel_q + 2'd1;

   // When the held word leaves this cycle, the search for the incoming word
   // must already start after it, otherwise back-to-back streaming would
   // revisit the channel that just fired.
   assign w_ptr_eff = w_fire ? w_sel_inc : ptr_q;

   demux_rr_pick u_pick (
      .mask_i  (ch_en),
      .start_i (w_ptr_eff),
      .idx_o   (w_rr_idx),
      .found_o (w_rr_found)
   );

   assign w_pick_ok = (cfg_mode == MODE_FIXED) ? 1'b1 : w_rr_found;
   assign w_pick    = (cfg_mode == MODE_FIXED) ? cfg_sel : w_rr_idx;

   // in_ready depends on out_ready via fire; out_valid depends only on state.
   assign in_ready  = (~w_full | w_fire) & w_pick_ok;
   assign w_acc     = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      if (w_fire) begin
         ptr_d   = w_sel_inc;
         state_d = ST_EMPTY;
      end
      // Target is latched only at acceptance; later cfg/mask changes cannot
      // retarget a held word.
      if (w_acc) begin
         state_d = ST_HOLD;
         data_d  = in_data;
         sel_d   = w_pick;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      w_onehot = '0;
      if (w_full) w_onehot[sel_q] = 1'b1;
   end

   assign out_valid = w_onehot;
   assign out_data  = data_q;
   assign out_sel   = sel_q;
   assign busy      = w_full;

endmodule : demux_dispatch_ctrl
`default_nettype wire

// File: tb/tb_demux_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_dispatch_ctrl
//  Purpose  : Directed self-checking bench for demux_dispatch_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux_dispatch_ctrl;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       cfg_mode;
   logic [1:0] cfg_sel;
   logic [3:0] ch_en;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [7:0] out_data;
   logic [1:0] out_sel;
   logic       busy;

   int n_total  = 0;
   int n_passed = 0;

   demux_dispatch_ctrl #(.DATA_W(8), .NUM_CH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .cfg_mode  (cfg_mode),
      .cfg_sel   (cfg_sel),
      .ch_en     (ch_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // advance one rising edge, then settle 1 time unit before sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hA5;
      cfg_mode  = 1'b0;
      cfg_sel   = 2'd0;
      ch_en     = 4'b1111;
      out_ready = 4'b0000;

      // ---------------- reset with in_valid high ----------------
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_busy",      32'(busy),      32'h0);
      chk("rst_out_data",  32'(out_data),  32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready",  32'(in_ready),  32'h1);
      chk("post_rst_out_valid", 32'(out_valid), 32'h0);

      // ---------------- first accept ----------------
      tick();
      chk("first_out_valid", 32'(out_valid), 32'h1);
      chk("first_out_sel",   32'(out_sel),   32'h0);
      chk("first_out_data",  32'(out_data),  32'hA5);
      chk("first_busy",      32'(busy),      32'h1);
      chk("first_in_ready_blocked", 32'(in_ready), 32'h0);

      // ---------------- round-robin streaming from fresh reset ----------------
      rst = 1'b1;
      #1;
      chk("rst2_busy", 32'(busy), 32'h0);
      in_valid  = 1'b1;
      out_ready = 4'b1111;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_data = 8'(i + 1);
         #1;
         chk($sformatf("stream_in_ready_%0d", i), 32'(in_ready), 32'h1);
         tick();
         chk($sformatf("stream_sel_%0d", i),   32'(out_sel),   32'(i % 4));
         chk($sformatf("stream_data_%0d", i),  32'(out_data),  32'(i + 1));
         chk($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'(4'b0001 << (i % 4)));
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drain_busy", 32'(busy), 32'h0);

      // ---------------- masked skip: ch_en=1010 (ptr now 0) ----------------
      ch_en    = 4'b1010;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 8'(8'h10 + i);
         tick();
         chk($sformatf("mask_sel_%0d", i), 32'(out_sel), ((i % 2) == 0) ? 32'd1 : 32'd3);
      end
      ch_en = 4'b0000;
      #1;
      chk("mask_zero_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk("mask_zero_busy",      32'(busy),      32'h0);
      chk("mask_zero_out_valid", 32'(out_valid), 32'h0);
      chk("mask_zero_in_ready2", 32'(in_ready),  32'h0);

      // ---------------- back-pressure in fixed mode ----------------
      cfg_mode  = 1'b1;
      cfg_sel   = 2'd2;
      ch_en     = 4'b1111;
      out_ready = 4'b1011;
      in_data   = 8'h5C;
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'h4);
      chk("bp_out_sel",   32'(out_sel),   32'h2);
      chk("bp_in_ready",  32'(in_ready),  32'h0);
      in_data = 8'h77;
      cfg_sel = 2'd1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("bp_hold_valid_%0d", i), 32'(out_valid), 32'h4);
         chk($sformatf("bp_hold_data_%0d", i),  32'(out_data),  32'h5C);
         chk($sformatf("bp_hold_sel_%0d", i),   32'(out_sel),   32'h2);
         chk($sformatf("bp_hold_ready_%0d", i), 32'(in_ready),  32'h0);
      end
      out_ready = 4'b1111;
      #1;
      chk("bp_release_in_ready", 32'(in_ready), 32'h1);
      tick();
      chk("bp_next_sel",   32'(out_sel),   32'h1);
      chk("bp_next_valid", 32'(out_valid), 32'h2);
      chk("bp_next_data",  32'(out_data),  32'h77);
      in_valid = 1'b0;
      tick();
      chk("bp_drain_busy", 32'(busy), 32'h0);

      // ---------------- async reset during HOLD (ptr is 2 here) ----------------
      cfg_mode  = 1'b0;
      out_ready = 4'b0000;
      in_valid  = 1'b1;
      in_data   = 8'h3C;
      tick();
      chk("ar_pre_sel",  32'(out_sel), 32'h2);
      chk("ar_pre_busy", 32'(busy),    32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_out_valid", 32'(out_valid), 32'h0);
      chk("ar_busy",      32'(busy),      32'h0);
      chk("ar_out_sel",   32'(out_sel),   32'h0);
      chk("ar_out_data",  32'(out_data),  32'h0);
      in_valid = 1'b0;
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 4'b1111;
      in_valid  = 1'b1;
      in_data   = 8'h99;
      tick();
      chk("ar_first_sel",   32'(out_sel),   32'h0);
      chk("ar_first_valid", 32'(out_valid), 32'h1);
      chk("ar_first_data",  32'(out_data),  32'h99);
      in_valid = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule : tb_demux_dispatch_ctrl
`default_nettype wire

// File: doc/demux_dispatch_ctrl.md
# demux_dispatch_ctrl

Sequencing controller for the 1:4 demultiplexer datapath. Accepts a single valid/ready input stream, registers each word in a one-entry holding stage, and steers it to one of four output channels, selected either round-robin over an enable mask or fixed by configuration. Sits between a single producer and four consumers. It drives the demux select and the one-hot channel valid, and it owns the channel-sharing policy.

## Interface
Parameters:
- DATA_W, 8, width of data word
- NUM_CH, 4, number of output channels (fixed at 4; select is 2 bits)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  producer has a word
- in_ready  output  1  controller accepts word this cycle
- in_data  input  DATA_W  input word
- cfg_mode  input  1  0 = round-robin over ch_en, 1 = fixed channel cfg_sel
- cfg_sel  input  2  target channel in fixed mode
- ch_en  input  4  per-channel enable mask (round-robin mode only)
- out_valid  output  4  one-hot valid for the target channel, 0 when empty
- out_ready  input  4  per-channel consumer ready
- out_data  output  DATA_W  held word, shared by all channels
- out_sel  output  2  demux select of the held word
- busy  output  1  holding stage full

## Operation
- State: `full` (0 = EMPTY, 1 = HOLD). Registers: `data_q`, `sel_q` (2 bits), `ptr` (2 bits, next round-robin start).
- fire = full & out_ready[sel_q]. acc = in_valid & in_ready.
- in_ready = (~full | fire) & pick_ok.
  - pick_ok = 1 in fixed mode.
  - pick_ok = |ch_en in round-robin mode.
- Target pick, evaluated combinationally at acc:
  - Fixed mode: cfg_sel.
  - Round-robin mode: the first channel with ch_en set, searching ptr_eff, ptr_eff+1, ptr_eff+2, ptr_eff+3 (mod 4).
  - ptr_eff = sel_q+1 (mod 4) if fire this cycle, otherwise ptr.
- Transitions:
  - EMPTY & acc -> HOLD: capture data_q and sel_q.
  - HOLD & fire & ~acc -> EMPTY.
  - HOLD & fire & acc -> HOLD, loading the new word (back-to-back).
  - HOLD & ~fire -> HOLD: data_q and sel_q stable, in_ready=0.
- ptr update: on fire, ptr <= sel_q+1 (mod 4), wrapping 3 -> 0. ptr does not advance in fixed mode unless a fire occurs; it then still tracks sel_q+1.
- out_valid = full ? (1 << sel_q) : 0. out_data = data_q. out_sel = sel_q. busy = full.
- Changes to ch_en, cfg_mode or cfg_sel while in HOLD never retarget the held word. They affect only the next pick.
- ch_en = 0 in round-robin mode: no acceptance. A word already held still drains.
- Once out_valid is asserted, it stays asserted with stable data until fire (valid/ready rule).

## Timing
- Reset (asynchronous, immediate):
  - full=0, data_q=0, sel_q=0, ptr=0.
  - Therefore out_valid=0, out_data=0, out_sel=0, busy=0.
- Latency: a word accepted at edge N appears on out_valid/out_data after edge N, i.e. 1 cycle.
- Throughput: 1 word per cycle when the target consumer is continuously ready.
- Reset mid-HOLD discards the held word. No out_valid is emitted after rst.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to out_valid.

## Structure
- Package demux_pkg:
  - NUM_CH=4, SEL_W=2.
  - Mode constants MODE_RR=1'b0, MODE_FIXED=1'b1.
- Sub-module demux_rr_pick: combinational first-set search of a 4-bit mask from a 2-bit start pointer. Outputs a 2-bit index and a found flag. It is reusable by other arbiters.

## Test plan
- Reset with in_valid=1: out_valid=0000, in_ready=1 after rst deasserts. After first accept of 0xA5 with ch_en=1111 and cfg_mode=0: out_valid=0001, out_sel=0, out_data=0xA5 one cycle later.
- Round-robin streaming: ch_en=1111, all out_ready=1, 8 words 0x01..0x08 back-to-back. Required response:
  - out_sel sequence 0,1,2,3,0,1,2,3.
  - One word per cycle; in_ready held at 1.
- Masked skip: ch_en=1010, 4 words. out_sel sequence 1,3,1,3. ch_en=0000 -> in_ready=0 and busy drains to 0.
- Back-pressure: fixed mode, cfg_sel=2, out_ready[2]=0 for 5 cycles.
  - out_valid=0100 with stable data; in_ready=0.
  - Changing cfg_sel to 1 mid-hold leaves out_sel=2.
  - When out_ready[2]=1 the word fires; the next word goes to channel 1.
- Async reset during HOLD: assert rst between edges. out_valid=0, busy=0, ptr=0 immediately. The first post-reset round-robin word goes to channel 0.
